// File: rtl/pipeline_register_chain.sv
// Elastic pipeline register: DEPTH stages of N-bit data, each with its own valid bit.
// Latency: DEPTH-1 edges from accept to output_register, transfer out at edge DEPTH.
// Backpressure: combinational ready chain from out_ready to in_ready, no bubble penalty.
module pipeline_register_chain #(
  parameter  int N     = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clock_enable,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  input_signal,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  output_register,
  output logic [CW-1:0] occupancy
);

  logic [N-1:0]     r_data [DEPTH];
  logic [DEPTH-1:0] r_v;
  logic [CW-1:0]    r_occ;

  logic [DEPTH-1:0] w_adv;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Ready chain: a stage advances when it holds an item and its successor
  // either is empty or is itself advancing this cycle.
  always_comb begin
    logic w_free;
    w_adv  = '0;
    w_free = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_adv[i] = clock_enable & r_v[i] & w_free;
      w_free   = ~r_v[i] | w_adv[i];
    end
  end

  // Reset is folded in so the producer never sees ready while state is held cleared.
  assign in_ready        = clock_enable & ~flush & ~reset & (~r_v[0] | w_adv[0]);
  assign out_valid       = r_v[DEPTH-1] & clock_enable;
  assign w_in_xfer       = in_valid & in_ready;
  assign w_out_xfer      = out_valid & out_ready;
  assign output_register = r_data[DEPTH-1];
  assign occupancy       = r_occ;

  // Data registers: only load on a move into the stage; empty stages keep stale data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else if (clock_enable && !flush) begin
      if (w_in_xfer) begin
        r_data[0] <= input_signal;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_adv[i-1]) begin
          r_data[i] <= r_data[i-1];
        end
      end
    end
  end

  // Valid bits: set on fill, cleared on drain without refill; flush clears all.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_v <= '0;
    end else if (flush) begin
      r_v <= '0;
    end else if (clock_enable) begin
      if (w_in_xfer) begin
        r_v[0] <= 1'b1;
      end else if (w_adv[0]) begin
        r_v[0] <= 1'b0;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_adv[i-1]) begin
          r_v[i] <= 1'b1;
        end else if (w_adv[i]) begin
          r_v[i] <= 1'b0;
        end
      end
    end
  end

  // Occupancy tracks in/out transfers; a simultaneous pair leaves it unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (clock_enable) begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_register_chain.sv
// Directed bench for pipeline_register_chain with DEPTH=3, N=32.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Expected values are hand-derived per step from the stage contents.
module tb_pipeline_register_chain;

  localparam int N     = 32;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          clock_enable;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  input_signal;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  output_register;
  logic [CW-1:0] occupancy;

  int checks = 0;
  int errors = 0;

  pipeline_register_chain #(.N(N), .DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .clock_enable    (clock_enable),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .input_signal    (input_signal),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .output_register (output_register),
    .occupancy       (occupancy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Full status check of the output side.
  task automatic st(input string tag, input logic iv_rdy, input logic ov, input logic [31:0] od,
                    input logic [31:0] occ);
    #1;
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, iv_rdy});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, ".data"},      output_register,    od);
    chk({tag, ".occ"},       {30'd0, occupancy}, occ);
  endtask

  initial begin
    reset        = 1'b1;
    clock_enable = 1'b1;
    flush        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    input_signal = '0;

    // Reset state while reset held
    #2;
    st("reset", 1'b0, 1'b0, 32'h0, 0);
    #10;
    reset = 1'b0;
    st("rel", 1'b1, 1'b0, 32'h0, 0);

    // Latency / throughput: 1,2,3 with out_ready=1
    in_valid = 1'b1; input_signal = 32'd1; out_ready = 1'b1;
    cyc(); input_signal = 32'd2; st("lat1", 1'b1, 1'b0, 32'h0, 1);
    cyc(); input_signal = 32'd3; st("lat2", 1'b1, 1'b0, 32'h0, 2);
    cyc(); in_valid = 1'b0;      st("lat3", 1'b1, 1'b1, 32'd1, 3);
    cyc();                       st("lat4", 1'b1, 1'b1, 32'd2, 2);
    cyc();                       st("lat5", 1'b1, 1'b1, 32'd3, 1);
    cyc();                       st("lat_empty", 1'b1, 1'b0, 32'd3, 0);

    // Back-pressure: offer 10..13 with out_ready=0
    in_valid = 1'b1; input_signal = 32'd10; out_ready = 1'b0;
    cyc(); input_signal = 32'd11;
    cyc(); input_signal = 32'd12;
    cyc(); input_signal = 32'd13; st("bp_full", 1'b0, 1'b1, 32'd10, 3);
    cyc();                        st("bp_hold", 1'b0, 1'b1, 32'd10, 3);
    out_ready = 1'b1;             st("bp_rel",  1'b1, 1'b1, 32'd10, 3);
    cyc(); in_valid = 1'b0;       st("bp_o1",   1'b1, 1'b1, 32'd11, 3);
    cyc();                        st("bp_o2",   1'b1, 1'b1, 32'd12, 2);
    cyc();                        st("bp_o3",   1'b1, 1'b1, 32'd13, 1);
    cyc();                        st("bp_empty", 1'b1, 1'b0, 32'd13, 0);

    // Two's complement stream, continuing into a full-pipe stall
    in_valid = 1'b1; input_signal = 32'hFFFF_FFF6;
    cyc(); input_signal = 32'h8000_0000;
    cyc(); input_signal = 32'h7FFF_FFFF;
    cyc(); input_signal = 32'h0000_0100; st("tc_neg10", 1'b1, 1'b1, 32'hFFFF_FFF6, 3);
    cyc(); input_signal = 32'h0000_0101; st("tc_min",   1'b1, 1'b1, 32'h8000_0000, 3);

    // Stall for 4 edges while full
    clock_enable = 1'b0; st("stall0", 1'b0, 1'b0, 32'h8000_0000, 3);
    for (int k = 0; k < 4; k++) begin
      cyc(); st("stall", 1'b0, 1'b0, 32'h8000_0000, 3);
    end
    clock_enable = 1'b1; st("resume", 1'b1, 1'b1, 32'h8000_0000, 3);
    cyc(); in_valid = 1'b0; st("tc_max", 1'b1, 1'b1, 32'h7FFF_FFFF, 3);
    cyc();                  st("post1",  1'b1, 1'b1, 32'h0000_0100, 2);

    // Flush with occupancy=2, head delivered in the flush cycle
    flush = 1'b1;            st("flush_cyc", 1'b0, 1'b1, 32'h0000_0100, 2);
    cyc(); flush = 1'b0;     st("flushed",   1'b1, 1'b0, 32'h0000_0100, 0);
    in_valid = 1'b1; input_signal = 32'h55;
    cyc(); in_valid = 1'b0;  st("fl_new1", 1'b1, 1'b0, 32'h0000_0100, 1);
    cyc();                   st("fl_new2", 1'b1, 1'b0, 32'h0000_0100, 1);
    cyc();                   st("fl_new3", 1'b1, 1'b1, 32'h55, 1);
    cyc();                   st("fl_new4", 1'b1, 1'b0, 32'h55, 0);

    // Async reset between edges with occupancy=2
    out_ready = 1'b0; in_valid = 1'b1; input_signal = 32'h77;
    cyc(); input_signal = 32'h88;
    cyc(); in_valid = 1'b0;
    cyc();                   st("pre_rst", 1'b1, 1'b1, 32'h77, 2);
    #1 reset = 1'b1;
    st("async_rst", 1'b0, 1'b0, 32'h0, 0);
    #3 reset = 1'b0;
    st("rst_rel", 1'b1, 1'b0, 32'h0, 0);

    // Resume after reset
    out_ready = 1'b1; in_valid = 1'b1; input_signal = 32'h99;
    cyc(); in_valid = 1'b0;  st("res1", 1'b1, 1'b0, 32'h0, 1);
    cyc();
    cyc();                   st("res3", 1'b1, 1'b1, 32'h99, 1);
    cyc();                   st("res4", 1'b1, 1'b0, 32'h99, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_register_chain.md
# pipeline_register_chain

Parametrised elastic pipeline register: DEPTH stages of N-bit two's-complement data, each with its own valid bit, moved forward under a valid/ready handshake with a global clock enable and a synchronous flush. It replaces the single enabled/resettable register in datapaths that must tolerate back-pressure and bubbles, for example ALU operand staging and inter-stage latches of the processor pipeline. It sustains one transfer per cycle when not stalled.

## Interface
- N, 32, data width in bits (≥1); data is carried bit-exact, sign is not interpreted
- DEPTH, 2, number of register stages (≥1)
- CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

- clock  input  1  rising-edge clock; the block's only clock
- reset  input  1  asynchronous, active-high; clears all state immediately
- clock_enable  input  1  global advance enable; 0 freezes all stages
- flush  input  1  synchronous clear of all valid bits; independent of clock_enable
- in_valid  input  1  producer presents input_signal
- in_ready  output  1  block accepts input this cycle (combinational)
- input_signal  input  N  data in
- out_valid  output  1  output_register holds a valid item (combinational gate of a registered bit)
- out_ready  input  1  consumer accepts the item
- output_register  output  N  data out; the last stage's data register
- occupancy  output  CW  number of valid stages, 0..DEPTH (registered)

## Operation
- Stage i holds data[i] and v[i]. Stage 0 is the input side; stage DEPTH-1 drives output_register.
- out_valid = v[DEPTH-1] & clock_enable. Output transfer = out_valid & out_ready.
- Stage i advances (adv[i]) when clock_enable & v[i] & (i==DEPTH-1 ? out_ready : (!v[i+1] | adv[i+1])). This is a combinational ready chain from the output back to the input, with no bubble penalty.
- in_ready = clock_enable & !flush & (!v[0] | adv[0]). Input transfer = in_valid & in_ready.
- On a clock edge with clock_enable=1 and flush=0:
  - stage i+1 loads data[i] and sets v[i+1] when adv[i];
  - stage i+1 clears v[i+1] when it drains and receives nothing;
  - stage 0 loads input_signal on an input transfer.
- Empty stages keep their stale data. Only the valid bits are cleared.
- flush=1 at an edge: every v[i] goes to 0 and data is unchanged. An output transfer presented in that same cycle still counts as delivered. in_ready is 0, so no input is taken.
- clock_enable=0 and flush=0: no state changes. in_ready=0 and out_valid=0.
- occupancy = popcount(v). Its next value is current + input transfer − output transfer, or 0 on flush.
- reset=1: asynchronously v=0, all data=0, output_register=0, occupancy=0. While reset is held, in_ready=0 and out_valid=0.

## Timing
- Reset values: output_register=0, out_valid=0, in_ready=0 while reset is asserted, occupancy=0. in_ready rises combinationally once reset is released and clock_enable=1.
- Latency: an item accepted at edge t with out_ready held at 1 shows on output_register/out_valid after edge t+DEPTH-1. It transfers out at edge t+DEPTH.
- Throughput: one item per cycle while in_valid=out_ready=clock_enable=1.
- Full (occupancy=DEPTH) with out_ready=0: in_ready=0. Raising out_ready makes in_ready=1 in the same cycle, so a simultaneous in and out transfer keeps occupancy at DEPTH.
- Empty: out_valid=0, and output_register shows the last delivered data.
- Reset asserted mid-transfer: takes effect without waiting for an edge. Any in-flight items are lost.
- Order is strict FIFO. No item is ever duplicated or dropped except by flush or reset.

## Test plan
- DEPTH=3, N=32: present 1, 2, 3 on consecutive cycles with out_ready=1. Required: outputs 1, 2, 3 appear on the 3rd, 4th and 5th edges after the first accept. in_ready stays 1 throughout and occupancy peaks at 3.
- Back-pressure, DEPTH=3: out_ready=0 while 4 items are offered. Required: 3 are accepted, then in_ready=0 and occupancy=3. Release out_ready and the items exit in order with no loss.
- Two's complement: pass 32'hFFFF_FFF6 (−10), 32'h8000_0000 and 32'h7FFF_FFFF. Required: each is bit-exact at output_register.
- Stall: drop clock_enable for 4 cycles while full, with in_valid=out_ready=1. Required: in_ready=0, out_valid=0, data and occupancy frozen. Resume and the stream continues unchanged.
- Flush: with occupancy=2 and out_ready=1, assert flush for one cycle. Required: the head item is delivered that cycle, then occupancy=0 and out_valid=0. A new item sent afterwards comes out with full latency DEPTH.
- Async reset between edges while occupancy=2. Required: out_valid, occupancy and output_register go to 0 before the next edge. Normal operation resumes after release.
